irq_prio_ctrl: RTL and testbench

//  Pending-request capture and grant stage around the 16-line priority encoder.

---
 rtl/irq_prio_ctrl.sv | 148 ++++++++++++++
 tb/tb_irq_prio_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_prio_ctrl.sv
// ---------------------------------------------------------------------------
// irq_prio_ctrl
//   Pending-request capture and grant stage. Request events are latched into
//   a pending register; the highest set pending bit (bit N-1 first) is
//   offered as an index on a valid/ready handshake. The pending bit of the
//   offered index is cleared when the offer is accepted.
//
//   Build option: define IRQ_EDGE_EN for rising-edge request detection.
//   Without it, requests are level-sensitive: a held line re-pends every
//   cycle.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   enable; gates new offers and the gs/eo flags
//   req         in   N request lines
//   code_ready  in   consumer ready
//   code_valid  out  offer valid (registered)
//   code        out  offered index (registered, holds while not valid)
//   gs          out  en & any pending
//   eo          out  en & nothing pending
//   pending     out  pending register
//   state_dbg   out  FSM state (0 = IDLE, 1 = OFFER), for observation
//
// Handshake: an offer is presented with code_valid=1 and code stable; it is
// transferred on a rising edge where code_valid && code_ready. Once raised,
// code_valid is never withdrawn before that transfer (only reset drops it).
// ---------------------------------------------------------------------------
module irq_prio_ctrl #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         code_ready,
  output logic         code_valid,
  output logic [W-1:0] code,
  output logic         gs,
  output logic         eo,
  output logic [N-1:0] pending,
  output logic         state_dbg
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

  state_e       state_q;
  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;
  logic [W-1:0] code_q;
  logic         code_valid_q;
  logic [N-1:0] evt;
  logic [N-1:0] clr_mask;
  logic [W-1:0] sel;
  logic         accept;

`ifdef IRQ_EDGE_EN
  // Registered copy of req. Reset to 0 so a line already high when reset
  // releases is seen as one rising edge.
  logic [N-1:0] req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req;
    end
  end

  assign evt = req & ~req_q;
`else
  assign evt = req;
`endif

  assign accept = code_valid_q & code_ready;

  always_comb begin
    clr_mask = '0;
    if (accept) begin
      clr_mask[code_q] = 1'b1;
    end
  end

  // New events are OR-ed in after the clear, so a fresh event on the bit
  // being accepted in the same cycle is kept.
  assign pend_d = (pend_q & ~clr_mask) | evt;

  // Ascending scan: the last set bit found (highest index) wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) begin
        sel = W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      code_q       <= '0;
      code_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en && (|pend_q)) begin
            code_q       <= sel;
            code_valid_q <= 1'b1;
            state_q      <= S_OFFER;
          end else begin
            code_valid_q <= 1'b0;
          end
        end
        S_OFFER: begin
          // No preemption and no withdrawal: only acceptance ends an offer.
          if (code_ready) begin
            code_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          code_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign code_valid = code_valid_q;
  assign code       = code_q;
  assign pending    = pend_q;
  assign gs         = en & (|pend_q);
  assign eo         = en & ~(|pend_q);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
module tb_irq_prio_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] req;
  logic        code_ready;
  logic        code_valid;
  logic [3:0]  code;
  logic        gs;
  logic        eo;
  logic [15:0] pending;
  logic        state_dbg;

  int total = 0;
  int bad   = 0;

  // Reference model state: set of pending lines, current offer (if any),
  // last request vector seen (used for edge detection only).
  logic [15:0] m_pend;
  logic        m_offer;
  logic [3:0]  m_code;
  logic [15:0] m_req_prev;

  logic [3:0]  exp_q[$];
  logic [3:0]  grant_log[$];

  irq_prio_ctrl #(.N(16), .W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .code_ready (code_ready),
    .code_valid (code_valid),
    .code       (code),
    .gs         (gs),
    .eo         (eo),
    .pending    (pending),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] highest(input logic [15:0] p);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (p[i]) begin
        r = 4'(i);
        break;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_pend     = '0;
    m_offer    = 1'b0;
    m_code     = '0;
    m_req_prev = '0;
    exp_q.delete();
  endtask

  // Advance the model across one rising edge with the currently driven inputs.
  task automatic model_edge();
    logic [15:0] events;
    logic [15:0] next_pend;
`ifdef IRQ_EDGE_EN
    events = req & ~m_req_prev;
`else
    events = req;
`endif
    next_pend = m_pend;
    if (m_offer && code_ready) begin
      next_pend[m_code] = 1'b0;
    end
    next_pend = next_pend | events;
    if (m_offer) begin
      if (code_ready) m_offer = 1'b0;
    end else if (en && (m_pend != 16'h0)) begin
      m_code  = highest(m_pend);
      m_offer = 1'b1;
    end
    m_pend     = next_pend;
    m_req_prev = req;
  endtask

  task automatic compare_outputs();
    check("valid",   32'(code_valid), 32'(m_offer));
    check("code",    32'(code),       32'(m_code));
    check("pending", 32'(pending),    32'(m_pend));
    check("gs",      32'(gs),         32'(en & (m_pend != 16'h0)));
    check("eo",      32'(eo),         32'(en & (m_pend == 16'h0)));
  endtask

  // One clock: log handshakes seen before the edge, step model, compare after.
  task automatic step();
    if (m_offer && code_ready) exp_q.push_back(m_code);
    if (code_valid && code_ready) begin
      grant_log.push_back(code);
      if (exp_q.size() == 0) begin
        check("spurious_grant", 32'(code), 32'hFFFF_FFFF);
      end else begin
        check("grant", 32'(code), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic drain();
    req        = '0;
    code_ready = 1'b1;
    en         = 1'b1;
    repeat (40) step();
    check("drained_pending", 32'(pending), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int vcount;
    rst_n      = 1'b0;
    en         = 1'b1;
    req        = '0;
    code_ready = 1'b0;
    model_reset();
    #12;
    // Test 1: reset state
    check("rst_valid",   32'(code_valid), 32'h0);
    check("rst_code",    32'(code),       32'h0);
    check("rst_gs",      32'(gs),         32'h0);
    check("rst_eo",      32'(eo),         32'h1);
    check("rst_pending", 32'(pending),    32'h0);
    rst_n = 1'b1;
    step();

    // Test 2: 8101 pulse, ready=1 -> 15, 8, 0
    grant_log.delete();
    code_ready = 1'b1;
    req = 16'h8101;
    step();
    req = '0;
    repeat (8) step();
    check("t2_ngrants", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      check("t2_g0", 32'(grant_log[0]), 32'd15);
      check("t2_g1", 32'(grant_log[1]), 32'd8);
      check("t2_g2", 32'(grant_log[2]), 32'd0);
    end
    check("t2_pending", 32'(pending), 32'h0);
    check("t2_eo",      32'(eo),      32'h1);

    // Test 3: offer 3 held with ready=0, req[12] arrives, no preemption
    code_ready = 1'b0;
    req = 16'h0008;
    step();
    req = '0;
    step();
    req = 16'h1000;
    for (int i = 0; i < 5; i++) begin
      step();
      req = '0;
      check("t3_hold_valid", 32'(code_valid), 32'h1);
      check("t3_hold_code",  32'(code),       32'd3);
    end
    grant_log.delete();
    code_ready = 1'b1;
    repeat (4) step();
    check("t3_ngrants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("t3_first",  32'(grant_log[0]), 32'd3);
      check("t3_second", 32'(grant_log[1]), 32'd12);
    end
    drain();

    // Test 4: en=0 captures but does not offer
    en  = 1'b0;
    req = 16'h0010;
    step();
    req = '0;
    step();
    step();
    check("t4_pending", 32'(pending),    32'h0010);
    check("t4_gs",      32'(gs),         32'h0);
    check("t4_eo",      32'(eo),         32'h0);
    check("t4_valid",   32'(code_valid), 32'h0);
    en = 1'b1;
    step();
    check("t4_valid_en", 32'(code_valid), 32'h1);
    check("t4_code_en",  32'(code),       32'd4);
    drain();

    // Test 5: event on the bit being accepted is kept
    code_ready = 1'b0;
    req = 16'h0020;
    step();
    req = '0;
    step();
    step();
    check("t5_offer", 32'(code), 32'd5);
    req = 16'h0020;
    code_ready = 1'b1;
    step();
    check("t5_kept", 32'(pending[5]), 32'h1);
    req = '0;
    code_ready = 1'b0;
    step();
    check("t5_reoffer_valid", 32'(code_valid), 32'h1);
    check("t5_reoffer_code",  32'(code),       32'd5);
    drain();

    // Test 6: async reset mid-offer
    code_ready = 1'b0;
    req = 16'h0040;
    step();
    req = '0;
    step();
    step();
    check("t6_pre_valid", 32'(code_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid",   32'(code_valid), 32'h0);
    check("t6_code",    32'(code),       32'h0);
    check("t6_pending", 32'(pending),    32'h0);
    check("t6_gs",      32'(gs),         32'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
    step();

    // Held request: level mode re-offers every 2 cycles, edge mode once
    code_ready = 1'b1;
    req = 16'h0004;
    step();
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (code_valid && code == 4'd2) vcount++;
    end
`ifdef IRQ_EDGE_EN
    check("held_offers", 32'(vcount), 32'd1);
`else
    check("held_offers", 32'(vcount), 32'd4);
`endif
    drain();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      en         = ($urandom_range(0, 7) != 0);
      code_ready = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 5))
        0:       req = 16'($urandom);
        1, 2:    req = 16'h1 << $urandom_range(0, 15);
        default: req = '0;
      endcase
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
